irq_priority_resolver: RTL

Upstream neighbour of the in-service register in the 8259A PIC. The block:
- synchronises and latches IR0–IR7 into the Interrupt Request Register (IRR);
- masks requests with the IMR;
- resolves the highest-priority request against the current ISR contents;
- drives INT and runs the two-pulse INTA sequence, producing the winner index and the read/vector/acknowledge strobes the ISR consumes.

It also owns the rotating-priority pointer (zero-level index).

---
 rtl/irq_priority_resolver_pkg.sv | 46 ++++
 rtl/irq_priority_resolver_sync.sv | 39 +++
 rtl/irq_priority_resolver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/irq_priority_resolver_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pic_pkg
//  Purpose : Shared constants, FSM state encodings and the rotating-priority
//            scan helper for the 8259A-style interrupt priority resolver.
//  Revision: 1.0  initial release
// ============================================================================
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    // Acknowledge sequencer states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK1 = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK2 = 2'd2;

    // Vector reported when the request vanished before the first INTA
    localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

    // Result of a rotated scan: offset is the distance from the base index,
    // so the absolute index is base + offset (mod 8).
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] offset;
    } win_t;

    // Returns the first set bit of vec when scanning base, base+1, ... base+7.
    // The loop runs from lowest to highest priority so the last hit wins.
    function automatic win_t rotWinner(input logic [NUM_IRQ-1:0] vec,
                                       input logic [IDX_W-1:0]   base);
        win_t             res;
        logic [IDX_W-1:0] off;
        res = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            off = k[IDX_W-1:0];
            if (vec[base + off]) begin
                res.found  = 1'b1;
                res.offset = off;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_resolver_sync.sv
`default_nettype none
// ============================================================================
//  Module  : irq_sync_edge
//  Purpose : Multi-flop synchroniser for one asynchronous IR line plus a
//            rising-edge detector on the synchronised level.
//  Ports   : clk, rst_n      - clock, async active-low reset
//            irIn            - raw asynchronous request line
//            irSync          - synchronised level (ir_s)
//            irRise          - high for one cycle after a 0->1 of irSync
//  Revision: 1.0  initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irIn,
    output logic irSync,
    output logic irRise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irIn};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign irSync = r_sync[SYNC_STAGES-1];
    assign irRise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_priority_resolver.sv
`default_nettype none
// ============================================================================
//  Module  : irq_priority_resolver
//  Purpose : IRR capture, masking, rotating-priority resolution against the
//            ISR, INT generation and the two-pulse INTA sequence of an
//            8259A-compatible PIC.
//  Ports   : ir_in[7:0]            raw requests        irr_value[7:0] IRR
//            ltim                  1=level, 0=edge      int_out        INT
//            imr[7:0]              1=masked             to_set[2:0]    winner
//            isr_value[7:0]        in-service bits      read_priority  strobe
//            inta_first/second     INTA pulses          send_vector    strobe
//            eoi_valid/eoi_index   EOI retire           second_ack     strobe
//            rotate_on_eoi         rotate on EOI        zero_level_index
//            set_priority_valid/index  set lowest priority
//  Revision: 1.0  initial release
// ============================================================================
module irq_priority_resolver
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [NUM_IRQ-1:0] isr_value,
    input  logic               inta_first,
    input  logic               inta_second,
    input  logic               eoi_valid,
    input  logic [IDX_W-1:0]   eoi_index,
    input  logic               rotate_on_eoi,
    input  logic               set_priority_valid,
    input  logic [IDX_W-1:0]   set_priority_index,
    output logic [NUM_IRQ-1:0] irr_value,
    output logic               int_out,
    output logic [IDX_W-1:0]   to_set,
    output logic               read_priority,
    output logic               send_vector,
    output logic               second_ack,
    output logic [IDX_W-1:0]   zero_level_index
);

    logic [NUM_IRQ-1:0] w_irS;
    logic [NUM_IRQ-1:0] w_irRise;

    logic [NUM_IRQ-1:0] r_irr;
    logic [1:0]         r_state;
    logic               r_int;
    logic [IDX_W-1:0]   r_toSet;
    logic               r_readPriority;
    logic               r_sendVector;
    logic [IDX_W-1:0]   r_zeroLevel;

    win_t               w_candWin;
    win_t               w_isrWin;
    logic [IDX_W-1:0]   w_winIdx;
    logic               w_pending;
    logic               w_ack;
    logic [NUM_IRQ-1:0] w_ackMask;
    logic [NUM_IRQ-1:0] w_irrNext;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .rst_n  (rst_n),
                .irIn   (ir_in[i]),
                .irSync (w_irS[i]),
                .irRise (w_irRise[i])
            );
        end
    endgenerate

    // Resolution: both vectors are scanned from the same base, so comparing
    // offsets tells whether an in-service level is at or above the winner.
    assign w_candWin = rotWinner(r_irr & ~imr, r_zeroLevel);
    assign w_isrWin  = rotWinner(isr_value, r_zeroLevel);
    assign w_winIdx  = r_zeroLevel + w_candWin.offset;
    assign w_pending = w_candWin.found &&
                       !(w_isrWin.found && (w_isrWin.offset <= w_candWin.offset));

    assign w_ack = (r_state == ST_WAIT_ACK1) && inta_first;

    always_comb begin
        w_ackMask = '0;
        if (w_ack && w_candWin.found) begin
            w_ackMask[w_winIdx] = 1'b1;
        end
    end

    // Edge mode: a bit survives only while the synchronised line stays high.
    assign w_irrNext = ltim ? w_irS : (w_irS & (r_irr | w_irRise));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irr <= '0;
        end else begin
            // Acknowledge clear is applied last so it beats a same-cycle set.
            r_irr <= w_irrNext & ~w_ackMask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_int          <= 1'b0;
            r_toSet        <= '0;
            r_readPriority <= 1'b0;
            r_sendVector   <= 1'b0;
        end else begin
            r_readPriority <= 1'b0;
            r_sendVector   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        r_int   <= 1'b1;
                        r_state <= ST_WAIT_ACK1;
                    end
                end
                ST_WAIT_ACK1: begin
                    // INT stays asserted even if the request disappears; the
                    // CPU is already committed to the acknowledge cycle.
                    if (inta_first) begin
                        r_toSet        <= w_candWin.found ? w_winIdx : SPURIOUS_IDX;
                        r_readPriority <= 1'b1;
                        r_int          <= 1'b0;
                        r_state        <= ST_WAIT_ACK2;
                    end
                end
                ST_WAIT_ACK2: begin
                    if (inta_second) begin
                        r_sendVector <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zeroLevel <= '0;
        end else if (set_priority_valid) begin
            r_zeroLevel <= set_priority_index + 3'd1;
        end else if (eoi_valid && rotate_on_eoi) begin
            r_zeroLevel <= eoi_index + 3'd1;
        end
    end

    assign irr_value        = r_irr;
    assign int_out          = r_int;
    assign to_set           = r_toSet;
    assign read_priority    = r_readPriority;
    assign send_vector      = r_sendVector;
    assign second_ack       = r_sendVector;
    assign zero_level_index = r_zeroLevel;

endmodule
`default_nettype wire
